rca_ls_arbiter: RTL and testbench

Arbitrates the load/store requests from the NUM_PORTS grid memory units of the active RCA onto the single shared data-memory port, and routes in-order read responses back to the originating unit. It sits between the grid load/store units and the memory interface. When `clear_fifos` from grid control switches accelerators, it drains in-flight loads and discards their responses, so stale data never reaches a newly selected RCA.

---
 rtl/rca_ls_arbiter_if.sv | 37 +++
 rtl/rca_ls_arbiter.sv | 144 ++++++++++++++
 tb/tb_rca_ls_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_ls_arbiter_if.sv
// Grid load/store request, shared memory port and response bundle.
// master = grid units plus memory model, slave = the arbiter.
interface rca_ls_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int XLEN      = 32
);
    logic [NUM_PORTS-1:0]              req_valid;
    logic [NUM_PORTS-1:0]              req_ready;
    logic [NUM_PORTS-1:0]              req_we;
    logic [NUM_PORTS-1:0][XLEN-1:0]    req_addr;
    logic [NUM_PORTS-1:0][XLEN-1:0]    req_wdata;
    logic [NUM_PORTS-1:0][XLEN/8-1:0]  req_be;
    logic                              mem_valid;
    logic                              mem_ready;
    logic                              mem_we;
    logic [XLEN-1:0]                   mem_addr;
    logic [XLEN-1:0]                   mem_wdata;
    logic [XLEN/8-1:0]                 mem_be;
    logic                              mem_rvalid;
    logic [XLEN-1:0]                   mem_rdata;
    logic [NUM_PORTS-1:0]              resp_valid;
    logic [XLEN-1:0]                   resp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        input  resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        output resp_valid, resp_data
    );
endinterface

// File: rtl/rca_ls_arbiter.sv
// Grid load/store arbiter onto the shared data-memory port with in-order tags.
// Define RCA_LS_ARB_RR_EN for round-robin; otherwise fixed lowest-index priority.
module rca_ls_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    rca_ls_arbiter_if.slave                  bus,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int BW = XLEN / 8;

    typedef enum logic {ARB, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [IW-1:0]        tags [MAX_OUTSTANDING];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full, empty;
    logic                 push, pop;
    logic                 grant_en, win_found, mem_vld, accept;
    logic [IW-1:0]        win;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] resp_valid_q;
    logic [XLEN-1:0]      resp_data_q;

    assign empty    = (count == '0);
    assign full     = (count == CW'(MAX_OUTSTANDING));
    assign eligible = full ? (bus.req_valid & bus.req_we) : bus.req_valid;

`ifdef RCA_LS_ARB_RR_EN
    logic [IW-1:0] rr_ptr;

    // rr_ptr holds the first port to search, i.e. last_grant + 1
    always_comb begin
        int j;
        win       = '0;
        win_found = 1'b0;
        j         = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!win_found && eligible[IW'(j)]) begin
                win       = IW'(j);
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (win == IW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
        end
    end
`else
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!win_found && eligible[i]) begin
                win       = IW'(i);
                win_found = 1'b1;
            end
        end
    end
`endif

    // Reset gates the grant so req_ready drops as soon as rst falls
    assign grant_en = rst && (state == ARB) && !clear;
    assign mem_vld  = grant_en && win_found;
    assign accept   = mem_vld && bus.mem_ready;
    assign push     = accept && !bus.req_we[win];
    assign pop      = bus.mem_rvalid && !empty;

    always_comb begin
        bus.mem_valid = mem_vld;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        bus.req_ready = '0;
        if (mem_vld) begin
            bus.mem_we    = bus.req_we[win];
            bus.mem_addr  = bus.req_addr[win];
            bus.mem_wdata = bus.req_wdata[win];
            bus.mem_be    = bus.req_be[win];
        end
        if (accept) begin
            bus.req_ready = NUM_PORTS'(1) << win;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB:     if (clear && !empty) state_nxt = DRAIN;
            DRAIN:   if (empty) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Responses popped while draining are dropped
            if (pop && state == ARB) begin
                resp_valid_q <= NUM_PORTS'(1) << tags[rd_ptr];
                resp_data_q  <= bus.mem_rdata;
            end else begin
                resp_valid_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= win;
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign outstanding    = count;
endmodule

// File: tb/tb_rca_ls_arbiter.sv
// Directed bench for rca_ls_arbiter with a response scoreboard.
// Expected grant order follows RCA_LS_ARB_RR_EN when it is defined.
module tb_rca_ls_arbiter;
    localparam int NP = 4;
    localparam int XL = 32;

    typedef struct {
        logic [NP-1:0] port;
        logic [XL-1:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [2:0] outstanding;
    int         checks = 0;
    int         passes = 0;
    exp_t       sbq[$];

    rca_ls_arbiter_if #(.NUM_PORTS(NP), .XLEN(XL)) bus ();

    rca_ls_arbiter #(
        .NUM_PORTS(NP),
        .XLEN(XL),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .bus(bus),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Every registered response must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && bus.resp_valid !== '0) begin
            if (sbq.size() == 0) begin
                chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_port", 64'(bus.resp_valid), 64'(e.port));
                chk("resp_data", 64'(bus.resp_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic idle();
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.mem_rvalid = 1'b0;
        clear          = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load(input int p);
        logic [NP-1:0] oh;
        oh = NP'(1) << p;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.req_valid  = oh;
        bus.req_we     = '0;
        #1 chk("load_grant", 64'(bus.req_ready), 64'(oh));
    endtask

    task automatic ret(input logic [XL-1:0] d, input int p, input bit keep);
        exp_t e;
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = d;
        if (keep) begin
            e.port = NP'(1) << p;
            e.data = d;
            sbq.push_back(e);
        end
    endtask

    initial begin
        logic [NP-1:0] eg;
        rst           = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = '0;
        for (int i = 0; i < NP; i++) begin
            bus.req_addr[i]  = 32'h1000 + 32'(i * 4);
            bus.req_wdata[i] = 32'h5000 + 32'(i);
            bus.req_be[i]    = 4'hF;
        end
        idle();
        bus.req_valid = '1;

        // Reset state with requests pending
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        @(negedge clk);
        idle();
        rst = 1'b1;

        // Port 2 store, combinational grant
        @(negedge clk);
        bus.req_addr[2]  = 32'h100;
        bus.req_wdata[2] = 32'hDEAD;
        bus.req_valid    = 4'b0100;
        bus.req_we       = 4'b0100;
        #1;
        chk("st_mem_valid", 64'(bus.mem_valid), 64'd1);
        chk("st_mem_addr", 64'(bus.mem_addr), 64'h100);
        chk("st_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD);
        chk("st_mem_we", 64'(bus.mem_we), 64'd1);
        chk("st_req_ready", 64'(bus.req_ready), 64'b0100);
        bus.req_addr[2]  = 32'h1008;

        // All ports request every cycle
        do_reset();
        @(negedge clk);
        bus.req_valid = '1;
        bus.req_we    = '1;
        for (int i = 0; i < 5; i++) begin
`ifdef RCA_LS_ARB_RR_EN
            eg = NP'(1) << (i % NP);
`else
            eg = 4'b0001;
`endif
            #1;
            chk("arb_grant", 64'(bus.req_ready), 64'(eg));
            chk("arb_addr", 64'(bus.mem_addr),
                64'(32'h1000 + 32'($clog2(eg) * 4)));
            @(negedge clk);
        end
        idle();

        // Fill the tag FIFO, fifth load blocked, store still passes
        do_reset();
        load(3);
        load(1);
        load(0);
        load(2);
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_we    = '0;
        #1;
        chk("full_block_ready", 64'(bus.req_ready), 64'd0);
        chk("full_block_valid", 64'(bus.mem_valid), 64'd0);
        chk("full_outstanding", 64'(outstanding), 64'd4);
        @(negedge clk);
        bus.req_valid = 4'b0011;
        bus.req_we    = 4'b0010;
        #1 chk("full_store_ok", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        idle();
        ret(32'hA, 3, 1'b1);
        ret(32'hB, 1, 1'b1);
        ret(32'hC, 0, 1'b1);
        ret(32'hD, 2, 1'b1);
        @(negedge clk);
        idle();
        #2;
        chk("ret_sb_empty", 64'(sbq.size()), 64'd0);
        chk("ret_outstanding", 64'(outstanding), 64'd0);

        // Full FIFO: pop and new load in the same cycle
        load(0);
        load(1);
        load(2);
        load(3);
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_we    = '0;
        begin
            exp_t e;
            e.port = 4'b0001;
            e.data = 32'h55;
            sbq.push_back(e);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h55;
        #1 chk("pop_same_block", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1 chk("pop_next_accept", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        idle();
        #1 chk("refill_outstanding", 64'(outstanding), 64'd4);
        ret(32'h61, 1, 1'b1);
        ret(32'h62, 2, 1'b1);
        ret(32'h63, 3, 1'b1);
        ret(32'h64, 0, 1'b1);
        @(negedge clk);
        idle();
        #2;
        chk("refill_sb_empty", 64'(sbq.size()), 64'd0);
        chk("refill_drained", 64'(outstanding), 64'd0);

        // Clear with two loads in flight
        load(1);
        load(3);
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_we    = '0;
        clear         = 1'b1;
        #1;
        chk("clr_mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("clr_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("drain_no_grant", 64'(bus.mem_valid), 64'd0);
        chk("drain_outstanding", 64'(outstanding), 64'd2);
        ret(32'h71, 1, 1'b0);
        ret(32'h72, 3, 1'b0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        chk("drain_empty", 64'(outstanding), 64'd0);
        chk("drain_still_held", 64'(bus.mem_valid), 64'd0);
        @(negedge clk);
        #1 chk("arb_resume", 64'(bus.req_ready), 64'b0001);

        // Asynchronous reset with three loads in flight
        load(1);
        load(2);
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_we    = '0;
        #1;
        chk("pre_rst_outstanding", 64'(outstanding), 64'd3);
        chk("pre_rst_ready", 64'(bus.req_ready), 64'b0100);
        #1 rst = 1'b0;
        #1;
        chk("async_outstanding", 64'(outstanding), 64'd0);
        chk("async_req_ready", 64'(bus.req_ready), 64'd0);
        chk("async_mem_valid", 64'(bus.mem_valid), 64'd0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        #2 chk("final_sb_empty", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
